// File: rtl/bc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bc_pkg
// Purpose  : Shared types, sizes and digit helper for the bulls/cows engine.
// Revision : 1.0 - initial release
// ============================================================================
package bc_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int SCORE_W    = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GEN   = 3'd1,
        S_ENTER = 3'd2,
        S_SCORE = 3'd3,
        S_DONE  = 3'd4
    } bc_state_t;

    function automatic logic is_valid_digit(input logic [DIGIT_W-1:0] d);
        return (d >= 4'd1) && (d <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bulls_cows_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : bulls_cows_engine_if
// Purpose  : Guess-digit valid/ready handshake between player input and engine.
// Revision : 1.0 - initial release
// ============================================================================
interface bulls_cows_engine_if;
    import bc_pkg::*;

    logic               digit_valid;
    logic [DIGIT_W-1:0] digit_in;
    logic               digit_ready;

    modport master (
        output digit_valid,
        output digit_in,
        input  digit_ready
    );

    modport slave (
        input  digit_valid,
        input  digit_in,
        output digit_ready
    );

endinterface
`default_nettype wire

// File: rtl/bc_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : bc_lfsr16
// Purpose  : Free-running 16-bit Galois LFSR (taps 16,14,13,11), low nibble out.
// Revision : 1.0 - initial release
// ============================================================================
module bc_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    output logic      [3:0] nibble
);

    logic [15:0] r_state;

    // An all-zero seed would lock the register at zero forever.
    if (SEED == 16'h0000) begin : g_seed_check
        $error("bc_lfsr16: SEED must be nonzero");
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SEED;
        end else begin
            r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign nibble = r_state[3:0];

endmodule
`default_nettype wire

// File: rtl/bulls_cows_engine.sv
`default_nettype none
// ============================================================================
// Module   : bulls_cows_engine
// Purpose  : Secret generation, guess entry and bulls/cows scoring for the panel.
//            Optional macro BC_HIDE_SECRET_EN masks the secret until S_DONE.
// Revision : 1.0 - initial release
// ============================================================================
module bulls_cows_engine
    import bc_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_TRIES = 10
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 new_game,
    bulls_cows_engine_if.slave        dig,
    output logic      [DIGIT_W-1:0]   secret_number_0,
    output logic      [DIGIT_W-1:0]   secret_number_1,
    output logic      [DIGIT_W-1:0]   secret_number_2,
    output logic      [DIGIT_W-1:0]   secret_number_3,
    output logic      [DIGIT_W-1:0]   guessed_number_0,
    output logic      [DIGIT_W-1:0]   guessed_number_1,
    output logic      [DIGIT_W-1:0]   guessed_number_2,
    output logic      [DIGIT_W-1:0]   guessed_number_3,
    output logic      [SCORE_W-1:0]   bulls,
    output logic      [SCORE_W-1:0]   cows,
    output logic                      score_valid,
    output logic      [3:0]           tries,
    output logic                      game_won,
    output logic                      game_lost,
    output logic                      busy
);

    localparam logic [3:0] c_max_tries = 4'(MAX_TRIES);

    if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_max_tries_check
        $error("bulls_cows_engine: MAX_TRIES must be in 1..15");
    end

    bc_state_t          r_state;
    bc_state_t          w_state_next;
    logic [DIGIT_W-1:0] r_secret [NUM_DIGITS];
    logic [DIGIT_W-1:0] r_guess  [NUM_DIGITS];
    logic [1:0]         r_gen_idx;
    logic [1:0]         r_guess_idx;
    logic [1:0]         r_score_idx;
    logic [SCORE_W-1:0] r_acc_bulls;
    logic [SCORE_W-1:0] r_acc_cows;
    logic [SCORE_W-1:0] r_bulls;
    logic [SCORE_W-1:0] r_cows;
    logic [3:0]         r_tries;
    logic               r_score_valid;
    logic               r_won;
    logic               r_lost;

    logic [DIGIT_W-1:0] w_rnd;
    logic               w_rnd_fresh;
    logic               w_digit_fresh;
    logic               w_bull;
    logic               w_cow;
    logic               w_gen_take;
    logic               w_digit_take;
    logic               w_score_last;
    logic               w_win;
    logic               w_lose;
    logic [SCORE_W-1:0] w_bulls_final;
    logic [SCORE_W-1:0] w_cows_final;
    logic [3:0]         w_tries_next;

    bc_lfsr16 #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .nibble (w_rnd)
    );

    // Candidate digits must be 1..9 and unique among slots already filled.
    always_comb begin
        w_rnd_fresh   = is_valid_digit(w_rnd);
        w_digit_fresh = is_valid_digit(dig.digit_in);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((2'(k) < r_gen_idx) && (r_secret[k] == w_rnd)) begin
                w_rnd_fresh = 1'b0;
            end
            if ((2'(k) < r_guess_idx) && (r_guess[k] == dig.digit_in)) begin
                w_digit_fresh = 1'b0;
            end
        end
    end

    always_comb begin
        w_bull = (r_guess[r_score_idx] == r_secret[r_score_idx]);
        w_cow  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((2'(k) != r_score_idx) && (r_guess[r_score_idx] == r_secret[k])) begin
                w_cow = 1'b1;
            end
        end
    end

    assign w_bulls_final = r_acc_bulls + {2'b00, w_bull};
    assign w_cows_final  = r_acc_cows + {2'b00, w_cow};
    assign w_tries_next  = (r_tries == 4'hF) ? r_tries : r_tries + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gen_take   = 1'b0;
        w_digit_take = 1'b0;
        w_score_last = 1'b0;
        w_win        = 1'b0;
        w_lose       = 1'b0;
        if (new_game) begin
            w_state_next = S_GEN;
        end else begin
            case (r_state)
                S_GEN: begin
                    if (w_rnd_fresh) begin
                        w_gen_take = 1'b1;
                        if (r_gen_idx == 2'd3) begin
                            w_state_next = S_ENTER;
                        end
                    end
                end
                S_ENTER: begin
                    if (dig.digit_valid && w_digit_fresh) begin
                        w_digit_take = 1'b1;
                        if (r_guess_idx == 2'd3) begin
                            w_state_next = S_SCORE;
                        end
                    end
                end
                S_SCORE: begin
                    if (r_score_idx == 2'd3) begin
                        w_score_last = 1'b1;
                        if (w_bulls_final == 3'd4) begin
                            w_win        = 1'b1;
                            w_state_next = S_DONE;
                        end else if (w_tries_next >= c_max_tries) begin
                            w_lose       = 1'b1;
                            w_state_next = S_DONE;
                        end else begin
                            w_state_next = S_ENTER;
                        end
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_secret[k] <= '0;
                r_guess[k]  <= '0;
            end
            r_gen_idx     <= '0;
            r_guess_idx   <= '0;
            r_score_idx   <= '0;
            r_acc_bulls   <= '0;
            r_acc_cows    <= '0;
            r_bulls       <= '0;
            r_cows        <= '0;
            r_tries       <= '0;
            r_score_valid <= 1'b0;
            r_won         <= 1'b0;
            r_lost        <= 1'b0;
        end else begin
            r_score_valid <= 1'b0;
            if (new_game) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    r_secret[k] <= '0;
                    r_guess[k]  <= '0;
                end
                r_gen_idx   <= '0;
                r_guess_idx <= '0;
                r_score_idx <= '0;
                r_acc_bulls <= '0;
                r_acc_cows  <= '0;
                r_bulls     <= '0;
                r_cows      <= '0;
                r_tries     <= '0;
                r_won       <= 1'b0;
                r_lost      <= 1'b0;
            end else begin
                if (w_gen_take) begin
                    r_secret[r_gen_idx] <= w_rnd;
                    r_gen_idx           <= r_gen_idx + 2'd1;
                end
                if (w_digit_take) begin
                    // Previous guess stays on the panel until the new guess starts.
                    if (r_guess_idx == 2'd0) begin
                        for (int k = 1; k < NUM_DIGITS; k++) begin
                            r_guess[k] <= '0;
                        end
                    end
                    r_guess[r_guess_idx] <= dig.digit_in;
                    r_guess_idx          <= r_guess_idx + 2'd1;
                end
                if (r_state == S_SCORE) begin
                    r_score_idx <= r_score_idx + 2'd1;
                    r_acc_bulls <= w_score_last ? '0 : w_bulls_final;
                    r_acc_cows  <= w_score_last ? '0 : w_cows_final;
                    if (w_score_last) begin
                        r_bulls       <= w_bulls_final;
                        r_cows        <= w_cows_final;
                        r_tries       <= w_tries_next;
                        r_score_valid <= 1'b1;
                        r_won         <= w_win;
                        r_lost        <= w_lose;
                    end
                end
            end
        end
    end

    assign dig.digit_ready = (r_state == S_ENTER);
    assign busy            = (r_state == S_GEN) || (r_state == S_SCORE);

`ifdef BC_HIDE_SECRET_EN
    assign secret_number_0 = (r_state == S_DONE) ? r_secret[0] : '0;
    assign secret_number_1 = (r_state == S_DONE) ? r_secret[1] : '0;
    assign secret_number_2 = (r_state == S_DONE) ? r_secret[2] : '0;
    assign secret_number_3 = (r_state == S_DONE) ? r_secret[3] : '0;
`else
    assign secret_number_0 = r_secret[0];
    assign secret_number_1 = r_secret[1];
    assign secret_number_2 = r_secret[2];
    assign secret_number_3 = r_secret[3];
`endif

    assign guessed_number_0 = r_guess[0];
    assign guessed_number_1 = r_guess[1];
    assign guessed_number_2 = r_guess[2];
    assign guessed_number_3 = r_guess[3];
    assign bulls            = r_bulls;
    assign cows             = r_cows;
    assign score_valid      = r_score_valid;
    assign tries            = r_tries;
    assign game_won         = r_won;
    assign game_lost        = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_bulls_cows_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_bulls_cows_engine
// Purpose  : Randomized scoreboard bench for bulls_cows_engine with a rule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bulls_cows_engine;
    import bc_pkg::*;

    localparam logic [15:0] SEED         = 16'hACE1;
    localparam int          TB_MAX_TRIES = 4;

    typedef struct {
        logic [2:0]  b;
        logic [2:0]  c;
        logic [3:0]  t;
        logic        won;
        logic        lost;
        logic [15:0] g;
        int          cyc;
    } exp_t;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic new_game = 1'b0;
    bulls_cows_engine_if dig();
    logic [3:0] sec0, sec1, sec2, sec3;
    logic [3:0] gs0, gs1, gs2, gs3;
    logic [2:0] bulls, cows;
    logic       score_valid;
    logic [3:0] tries;
    logic       game_won, game_lost, busy;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    logic [15:0] m_lfsr;
    int          m_secret [4];
    int          m_disp   [4];
    int          m_gidx;
    int          m_tries;
    bit          m_won;
    bit          m_lost;

    bulls_cows_engine #(
        .LFSR_SEED        (SEED),
        .MAX_TRIES        (TB_MAX_TRIES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .new_game         (new_game),
        .dig              (dig),
        .secret_number_0  (sec0),
        .secret_number_1  (sec1),
        .secret_number_2  (sec2),
        .secret_number_3  (sec3),
        .guessed_number_0 (gs0),
        .guessed_number_1 (gs1),
        .guessed_number_2 (gs2),
        .guessed_number_3 (gs3),
        .bulls            (bulls),
        .cows             (cows),
        .score_valid      (score_valid),
        .tries            (tries),
        .game_won         (game_won),
        .game_lost        (game_lost),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= SEED;
        else      m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic logic [15:0] guess16();
        return {gs3, gs2, gs1, gs0};
    endfunction

    function automatic logic [15:0] disp16();
        return {4'(m_disp[3]), 4'(m_disp[2]), 4'(m_disp[1]), 4'(m_disp[0])};
    endfunction

    function automatic logic any_output();
        return |{sec0, sec1, sec2, sec3, gs0, gs1, gs2, gs3, bulls, cows,
                 score_valid, tries, game_won, game_lost, busy, dig.digit_ready};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired at t=%0t", name, $time);
    endtask

    // Walk the LFSR sequence and keep the first four distinct digits in 1..9.
    task automatic predict_secret(input logic [15:0] start, output int ncyc);
        logic [15:0] v;
        int filled, d;
        bit seen;
        v = start; filled = 0; ncyc = 0;
        while (filled < 4 && ncyc < 1000) begin
            d = int'(v[3:0]);
            seen = 0;
            for (int k = 0; k < filled; k++) if (m_secret[k] == d) seen = 1;
            if (d >= 1 && d <= 9 && !seen) begin
                m_secret[filled] = d;
                filled++;
            end
            ncyc++;
            v = lfsr_step(v);
        end
    endtask

    task automatic model_score(input int hs_cyc);
        exp_t e;
        int b, c;
        b = 0; c = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (m_disp[i] == m_secret[j]) begin
                    if (i == j) b++;
                    else        c++;
                end
        m_tries = (m_tries == 15) ? 15 : m_tries + 1;
        m_won   = (b == 4);
        m_lost  = !m_won && (m_tries >= TB_MAX_TRIES);
        e.b = 3'(b); e.c = 3'(c); e.t = 4'(m_tries);
        e.won = m_won; e.lost = m_lost; e.g = disp16(); e.cyc = hs_cyc + 5;
        sb_q.push_back(e);
    endtask

    task automatic model_handshake(input int d, input int hs_cyc);
        bit dup;
        dup = 0;
        for (int k = 0; k < m_gidx; k++) if (m_disp[k] == d) dup = 1;
        if (d >= 1 && d <= 9 && !dup) begin
            if (m_gidx == 0) for (int k = 0; k < 4; k++) m_disp[k] = 0;
            m_disp[m_gidx] = d;
            m_gidx++;
            if (m_gidx == 4) begin
                m_gidx = 0;
                model_score(hs_cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst && score_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_score_valid: got 1 expected 0 at t=%0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("score_time",   cyc, mon_e.cyc);
                check("bulls",        bulls, mon_e.b);
                check("cows",         cows, mon_e.c);
                check("tries",        tries, mon_e.t);
                check("game_won",     game_won, mon_e.won);
                check("game_lost",    game_lost, mon_e.lost);
                check("scored_guess", guess16(), mon_e.g);
                check("ready_after",  dig.digit_ready, !(mon_e.won || mon_e.lost));
                check("busy_after",   busy, 0);
            end
        end
    end

    task automatic start_game(input bit with_digit);
        int n, c0, ncyc;
        bit ok;
        new_game = 1'b1;
        if (with_digit) begin
            dig.digit_valid = 1'b1;
            dig.digit_in    = 4'd5;
        end
        predict_secret(lfsr_step(m_lfsr), ncyc);
        c0 = cyc;
        m_tries = 0; m_won = 0; m_lost = 0; m_gidx = 0;
        for (int k = 0; k < 4; k++) m_disp[k] = 0;
        @(posedge clk); #1;
        new_game        = 1'b0;
        dig.digit_valid = 1'b0;
        check("newgame_busy", busy, 1);
        check("newgame_score_clear", {bulls, cows, tries, game_won, game_lost, score_valid}, 0);
        check("newgame_guess_clear", guess16(), 0);
        n = 0;
        while (!dig.digit_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!dig.digit_ready) begin
            fail_now("gen_timeout");
        end else begin
            check("gen_latency", cyc, c0 + ncyc + 1);
            check("secret", {sec3, sec2, sec1, sec0},
                  {4'(m_secret[3]), 4'(m_secret[2]), 4'(m_secret[1]), 4'(m_secret[0])});
            ok = (sec0 != sec1) && (sec0 != sec2) && (sec0 != sec3) &&
                 (sec1 != sec2) && (sec1 != sec3) && (sec2 != sec3) &&
                 is_valid_digit(sec0) && is_valid_digit(sec1) &&
                 is_valid_digit(sec2) && is_valid_digit(sec3);
            check("secret_legal", ok, 1);
            check("tries_zero", tries, 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_digit(input int d, input bit must_ready);
        int n;
        dig.digit_valid = 1'b1;
        dig.digit_in    = 4'(d);
        @(negedge clk);
        if (must_ready) check("ready_held", dig.digit_ready, 1);
        n = 0;
        while (!dig.digit_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!dig.digit_ready) begin
            fail_now("ready_timeout");
            @(posedge clk); #1;
            dig.digit_valid = 1'b0;
        end else begin
            model_handshake(d, cyc);
            @(posedge clk); #1;
            dig.digit_valid = 1'b0;
            check("guess_display", guess16(), disp16());
        end
    endtask

    task automatic send_guess(input int g [4], input bit noisy, input bit must_ready);
        int r;
        for (int i = 0; i < 4; i++) begin
            if (noisy && $urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 2);
                if (r == 1)                        send_digit($urandom_range(10, 15), must_ready);
                else if (r == 2 && m_gidx > 0)     send_digit(m_disp[$urandom_range(0, m_gidx - 1)], must_ready);
                else                               send_digit(0, must_ready);
            end
            send_digit(g[i], must_ready);
        end
    endtask

    task automatic wait_sb();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            fail_now("score_timeout");
            sb_q.delete();
        end
        @(posedge clk); #1;
    endtask

    function automatic void random_guess(output int g [4]);
        int pool [9];
        int j, t;
        for (int k = 0; k < 9; k++) pool[k] = k + 1;
        for (int k = 8; k > 0; k--) begin
            j = $urandom_range(0, k);
            t = pool[k]; pool[k] = pool[j]; pool[j] = t;
        end
        for (int k = 0; k < 4; k++) g[k] = pool[k];
    endfunction

    initial begin
        int g [4];
        int seq [7];
        int x, guesses;
        bit used;
        dig.digit_valid = 1'b0;
        dig.digit_in    = 4'd0;
        seq = '{0, 12, 4, 4, 6, 2, 8};

        repeat (3) @(posedge clk); #1;
        check("reset_outputs", any_output(), 0);
        rst = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("idle_ready", dig.digit_ready, 0);
        check("idle_busy", busy, 0);

        start_game(0);

        // One bull (slot 2), two cows (slots 0/1 swapped), one miss.
        x = 0;
        for (int d = 9; d >= 1; d--) begin
            used = 0;
            for (int k = 0; k < 4; k++) if (m_secret[k] == d) used = 1;
            if (!used) x = d;
        end
        g = '{m_secret[1], m_secret[0], m_secret[2], x};
        send_guess(g, 0, 1);
        wait_sb();

        check("prev_guess_held", guess16(), disp16());
        foreach (seq[i]) send_digit(seq[i], 1);
        check("reject_seq_guess", guess16(), 16'h8264);
        wait_sb();

        if (!m_won) begin
            g = '{m_secret[0], m_secret[1], m_secret[2], m_secret[3]};
            send_guess(g, 0, 0);
            wait_sb();
        end
        check("won_level", game_won, 1);
        dig.digit_valid = 1'b1;
        dig.digit_in    = 4'd3;
        repeat (6) @(posedge clk); #1;
        dig.digit_valid = 1'b0;
        check("done_ready", dig.digit_ready, 0);
        check("done_guess_hold", guess16(), disp16());
        check("done_won_hold", game_won, 1);

        start_game(0);
        for (int t = 0; t < TB_MAX_TRIES; t++) begin
            g = '{m_secret[1], m_secret[2], m_secret[3], m_secret[0]};
            send_guess(g, 1, 0);
            wait_sb();
        end
        check("lost_level", game_lost, 1);
        check("lost_ready", dig.digit_ready, 0);
        start_game(1);

        send_digit($urandom_range(1, 9), 1);
        start_game(1);

        for (int gi = 0; gi < 6; gi++) begin
            start_game(0);
            guesses = 0;
            while (!m_won && !m_lost && guesses <= TB_MAX_TRIES) begin
                if ($urandom_range(0, 2) == 0)
                    g = '{m_secret[0], m_secret[1], m_secret[2], m_secret[3]};
                else
                    random_guess(g);
                send_guess(g, 1, 0);
                wait_sb();
                guesses++;
            end
        end

        start_game(0);
        random_guess(g);
        send_guess(g, 0, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("reset_mid_score", any_output(), 0);
        sb_q.delete();
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b1;
        repeat (8) @(posedge clk); #1;
        check("post_reset_ready", dig.digit_ready, 0);
        check("post_reset_busy", busy, 0);
        start_game(0);
        random_guess(g);
        send_guess(g, 1, 0);
        wait_sb();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bulls_cows_engine.md
Name: bulls_cows_engine

Overview:
Game-control stage directly upstream of the VGA panel display. Generates a 4-digit secret with distinct digits 1..9 and accepts player guesses digit by digit over a valid/ready handshake. Scores each guess into bulls and cows and drives the secret, guess and score buses that the panel renders. It also tracks tries and win/loss.

Parameters:
LFSR_SEED, 16'hACE1, reset value of the free-running LFSR; must be nonzero (elaboration assertion).
MAX_TRIES, 10, number of scored guesses before loss; legal range 1..15.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
new_game  in  1  start/restart pulse
digit_valid  in  1  guess digit offered
digit_in  in  4  guess digit value
digit_ready  out  1  engine accepts a digit this cycle
secret_number_0..3  out  4 each  secret digits, slot 0 leftmost
guessed_number_0..3  out  4 each  current or last guess digits
bulls  out  3  bulls of the last scored guess, 0..4
cows  out  3  cows of the last scored guess, 0..4
score_valid  out  1  one-cycle pulse when bulls/cows update
tries  out  4  scored guesses this game
game_won  out  1  level, held until new_game
game_lost  out  1  level, held until new_game
busy  out  1  high in S_GEN or S_SCORE

Behaviour:
- Reset (rst=0, asynchronous): state S_IDLE; all outputs 0; LFSR=LFSR_SEED. Takes effect mid-operation immediately.
- LFSR: 16-bit Galois, taps 16,14,13,11. Advances every clk cycle in every state.
- Priority: new_game outranks everything, including a same-cycle digit handshake (that digit is dropped).
- On new_game in any state:
  - go to S_GEN
  - clear secret, guess, bulls, cows, tries, game_won, game_lost
  - a new_game during S_GEN restarts generation from slot 0
- S_GEN: each cycle take lfsr[3:0]. Accept it into the next secret slot if it is in 1..9 and differs from every already-filled slot; otherwise discard. After the 4th slot is filled, go to S_ENTER next cycle.
- S_ENTER:
  - digit_ready=1
  - handshake = digit_valid & digit_ready
  - digits 0 or 10..15 are rejected with no slot consumed; ready stays high
  - a digit equal to one already entered in this guess is rejected the same way
  - the previous guess and score stay visible until the first accepted digit of a new guess; on that handshake guessed_number_1..3 clear to 0 and slot 0 is written
  - slots fill in order 0..3; the 4th handshake moves to S_SCORE
- S_SCORE: exactly 4 cycles, index i=0..3.
  - bull if g[i]==s[i]
  - cow if g[i]==s[j] for some j≠i
  - accumulate in internal 3-bit counters
  - on the 4th cycle's edge, register bulls/cows, increment tries (saturate at 15) and pulse score_valid
- Timing: if the 4th handshake is in cycle N, score_valid is high in cycle N+5 only, with new bulls/cows/tries visible in that cycle.
- Exit from scoring, in the same cycle as score_valid:
  - bulls==4: go to S_DONE and set game_won
  - else tries==MAX_TRIES: go to S_DONE and set game_lost
  - else go to S_ENTER
- S_DONE: digit_ready=0; hold all outputs; wait for new_game.
- S_IDLE: digit_ready=0; wait for new_game.
- Invariants:
  - score_valid never asserts outside S_SCORE exit
  - bulls+cows ≤ 4
  - game_won and game_lost are never both 1

Optional Feature:
BC_HIDE_SECRET_EN.
- Defined: secret_number_0..3 drive 0 except in S_DONE, where the true secret is revealed; internal secret registers are unaffected.
- Undefined: secret_number_0..3 always drive the stored secret (debug/demo mode).

Decomposition:
- Package bc_pkg:
  - state enum {S_IDLE,S_GEN,S_ENTER,S_SCORE,S_DONE}
  - NUM_DIGITS=4, DIGIT_W=4, SCORE_W=3
  - function is_valid_digit (1..9)
- Sub-module bc_lfsr16: free-running LFSR with SEED parameter and asynchronous active-low reset.

Test Plan:
- rst=0 asserted mid-S_SCORE -> all outputs 0 in the same cycle, digit_ready=0; after release the engine stays in S_IDLE until new_game.
- new_game (BC_HIDE_SECRET_EN undefined) -> within 200 cycles digit_ready=1; secret digits are pairwise distinct and each in 1..9; tries=0.
- Secret read as 3,7,1,9; guess 7,3,1,5 -> bulls=1, cows=2, single score_valid 5 cycles after the 4th handshake, tries=1, digit_ready back to 1.
- In S_ENTER drive 0, 12, 4, 4, 6, 2, 8 -> guessed_number_* = 4,6,2,8; the rejected digits consume no slot; ready stays high throughout.
- Guess equal to secret -> bulls=4, cows=0, game_won=1, digit_ready=0; further digit_valid is ignored with guess outputs unchanged.
- MAX_TRIES=2, two non-winning guesses -> game_lost=1 at the 2nd score_valid; then new_game together with digit_valid -> digit dropped, busy=1, all score outputs cleared.
